wavelet_unit: RTL and testbench
===============================

WAVELET_UNIT -- requirements
Module: wavelet_unit

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, 32'h4000_0000, byte base of the register window.
REQ-002 SHALL have parameter N, 8, block edge in samples; legal values 8 or 16.
REQ-003 SHALL have parameter DW, 8, signed sample width.
REQ-004 SHALL have parameter MAX_LEVELS, 3, maximum decomposition levels; must be at most log2(N).
REQ-005 SHALL have port clk_i, input, 1, the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port resetn_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports valid_i in 1, ready_o out 1, wstrb_i in 4, addr_i in 32, wdata_i in 32, rdata_o out 32; these form the native bus slave.

Function
REQ-008 SHALL map the input array at BASE+0..N*N-1, the output array at BASE+N*N..2*N*N-1 and CTRL at BASE+2*N*N; data words are little-endian, four samples per word.
REQ-009 SHALL pulse ready_o for one cycle on the cycle after an accepted valid_i, and deassert ready_o the cycle after the pulse; wstrb_i selects which byte lanes are written.
REQ-010 SHALL, on a data-region read while busy, hold ready_o low until done, then respond.
REQ-011 SHALL answer CTRL reads immediately, even while busy.
REQ-012 SHALL complete out-of-window accesses with rdata_o=0 and no side effect.
REQ-013 SHALL decode a CTRL write with bit0=1 as start, with bits[5:4] giving the level count; 0 means 1, and values above MAX_LEVELS clamp to MAX_LEVELS.
REQ-014 SHALL report CTRL read bits as: bit0 busy; bit1 done, sticky and cleared by any CTRL write; bit2 err, sticky and cleared by any CTRL write; bits[5:4] levels used.
REQ-015 SHALL, on a start or an input-region write while busy, drop the write, still pulse ready_o, and set err.
REQ-016 SHALL run states IDLE -> LOAD (1 cycle) -> ROW -> XPOSE -> COL -> XPOSE -> (next level: ROW | last: STORE (1 cycle)) -> IDLE; done is set on the STORE->IDLE transition.
REQ-017 SHALL, at level l (0-based), process the top-left LxL region with L=N>>l and pass the remaining samples through unchanged.
REQ-018 SHALL, in each ROW/COL pass, handle all N lines in parallel lanes, one output pair k per cycle for k=0..L/2-1, plus a 2-cycle select/multiply pipeline; each pass takes L/2+2 cycles and each XPOSE takes 1 cycle.
REQ-019 SHALL hold busy for exactly 2 + sum over levels of 2*(L/2+3) cycles; this is 34 for N=8 with 3 levels.
REQ-020 SHALL compute low[k] = floor((-x[2k-2]+2x[2k-1]+6x[2k]+2x[2k+1]-x[2k+2])/8), written to index k.
REQ-021 SHALL compute high[k] = floor((-x[2k]+2x[2k+1]-x[2k+2])/2), written to index L/2+k.
REQ-022 SHALL use symmetric extension at line edges: index -i maps to i, and index L-1+i maps to L-1-i.
REQ-023 SHALL accumulate in DW+4 bits signed and implement the floor by arithmetic right shift.
REQ-024 SHALL leave the output array unchanged until STORE, and SHALL NOT take a snapshot of the input array until LOAD.

Reset
REQ-025 SHALL, while resetn_i is low and at any time, asynchronously clear ready_o, rdata_o, busy, done, err and the FSM (to IDLE); an operation in progress is abandoned.
REQ-026 SHALL NOT reset the data arrays; a read after reset returns stale contents.

Configuration
REQ-027 SHALL, when WAVELET_SAT_EN is defined, saturate each coefficient to [-2^(DW-1), 2^(DW-1)-1].
REQ-028 SHALL, when WAVELET_SAT_EN is undefined, keep the low DW bits of each coefficient (two's-complement wrap).

Structure
REQ-029 SHALL define the FSM state encoding, the tap constants (-1,2,6,2,-1 / -1,2,-1), the CTRL bit positions and the mirror-index function in package wavelet_pkg.
REQ-030 SHALL instantiate sub-module dwt53_lane once per lane; it takes 5 taps, gives low/high outputs and contains the pipeline and saturation/wrap logic.

Verification
REQ-031 SHALL cover: all-zero input, 3 levels, N=8 -> all outputs 0, with busy high for 34 cycles.
REQ-032 SHALL cover: all samples 16, 3 levels -> output[0][0]=16 and all other coefficients 0.
REQ-033 SHALL cover: every row 127,-128 alternating, 1 level -> rows 0-3 cols 0-3 = -1; rows 0-3 cols 4-7 = -128 with SAT_EN, and 1 without; rows 4-7 = 0.
REQ-034 SHALL cover: output-region read issued mid-operation -> ready_o low until done, then correct data.
REQ-035 SHALL cover: start written while busy -> ignored, CTRL read returns err=1; the next CTRL write clears it.
REQ-036 SHALL cover: resetn_i low mid-pass -> CTRL reads 0 afterwards; a fresh start then completes normally.

Source files
------------

// File: rtl/wavelet_pkg.sv
// Shared definitions for the 5/3 wavelet unit: FSM states, filter taps,
// CTRL register bit positions and the symmetric-extension index helper.
package wavelet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROW,
    ST_XPOSE,
    ST_COL,
    ST_STORE
  } state_e;

  localparam int TAP_LO [5] = '{-1, 2, 6, 2, -1};
  localparam int TAP_HI [3] = '{-1, 2, -1};

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_DONE    = 1;
  localparam int CTRL_ERR     = 2;
  localparam int CTRL_LVL_LSB = 4;

  // Reflect an out-of-line index back into 0..len-1 (whole-sample symmetry).
  // A second reflection covers the 2-sample line where -2 maps past the end.
  function automatic int mirror_idx(input int idx, input int len);
    int m;
    m = (idx < 0) ? -idx : idx;
    if (m > len - 1) m = 2 * (len - 1) - m;
    if (m < 0) m = -m;
    return m;
  endfunction

endpackage

// File: rtl/wavelet_unit_lane.sv
// One 5/3 lifting lane: registers five taps, forms low/high coefficients (WAVELET_SAT_EN selects saturate vs wrap).
module dwt53_lane
  import wavelet_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 vld_i,
  input  logic signed [DW-1:0] x_i [5],
  output logic                 vld_o,
  output logic signed [DW-1:0] low_o,
  output logic signed [DW-1:0] high_o
);

  localparam int AW = DW + 4;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

  logic                 vld_p0, vld_p1;
  logic signed [DW-1:0] x_p0 [5];
  logic signed [DW-1:0] low_p1, high_p1;
  logic signed [AW-1:0] acc_lo, acc_hi;

  function automatic logic signed [AW-1:0] floor_shr(input logic signed [AW-1:0] v,
                                                     input int sh);
    return v >>> sh;
  endfunction

  function automatic logic signed [DW-1:0] fit(input logic signed [AW-1:0] v);
`ifdef WAVELET_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[DW-1:0];
    if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  always_comb begin
    acc_lo = '0;
    acc_hi = '0;
    for (int i = 0; i < 5; i++) acc_lo += AW'(TAP_LO[i]) * AW'(x_p0[i]);
    for (int i = 0; i < 3; i++) acc_hi += AW'(TAP_HI[i]) * AW'(x_p0[i+2]);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vld_i;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    // p0: tap select captured
    x_p0    <= x_i;
    // p1: multiply-accumulate, floor, saturate/wrap
    low_p1  <= fit(floor_shr(acc_lo, 3));
    high_p1 <= fit(floor_shr(acc_hi, 1));
  end

  assign vld_o  = vld_p1;
  assign low_o  = low_p1;
  assign high_o = high_p1;

endmodule

// File: rtl/wavelet_unit.sv
// Memory-mapped 2-D 5/3 wavelet engine on an NxN signed block, multi-level.
// Coefficient overflow handling is set by the WAVELET_SAT_EN macro (in dwt53_lane).
module wavelet_unit
  import wavelet_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int          N            = 8,
  parameter int          DW           = 8,
  parameter int          MAX_LEVELS   = 3
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  localparam int IW = $clog2(N);
  localparam int NN = N * N;
  localparam int SW = $clog2(NN);

  state_e      state;
  logic [IW:0] cnt;
  logic [1:0]  lvl, levels;
  logic        col_phase, done, err, pending;
  logic [31:0] pend_off;

  logic signed [DW-1:0] in_mem  [NN];
  logic signed [DW-1:0] out_mem [NN];
  logic signed [DW-1:0] w [N][N];
  logic signed [DW-1:0] t [N][N];

  logic [31:0] off, rd_off, rd_word, ctrl_word;
  logic        is_wr, in_rgn, out_rgn, ctrl_rgn, busy, accept;
  logic [IW:0] l_w, lh;
  logic        pass_act, issue_vld, pass_end, vld_all;
  logic [IW-1:0] tap_idx [5];
  logic [IW-1:0] k_p0, k_p1;
  logic signed [DW-1:0] tap_sel [N][5];
  logic [N-1:0]         vld_lane;
  logic signed [DW-1:0] low_c  [N];
  logic signed [DW-1:0] high_c [N];

  function automatic logic [1:0] clamp_levels(input logic [1:0] f);
    if (f == 2'd0) return 2'd1;
    if (int'(f) > MAX_LEVELS) return 2'(MAX_LEVELS);
    return f;
  endfunction

  assign off       = addr_i - BASE_ADDRESS;
  assign is_wr     = |wstrb_i;
  assign in_rgn    = off < 32'(NN);
  assign out_rgn   = !in_rgn && (off < 32'(2 * NN));
  assign ctrl_rgn  = off[31:2] == 30'(2 * NN / 4);
  assign busy      = state != ST_IDLE;
  assign accept    = valid_i && !ready_o && !pending;
  assign l_w       = (IW + 1)'(N >> lvl);
  assign lh        = l_w >> 1;
  assign pass_act  = (state == ST_ROW) || (state == ST_COL);
  assign issue_vld = pass_act && (cnt < lh);
  assign pass_end  = pass_act && (cnt == lh + 1'b1);
  assign vld_all   = &vld_lane;

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_BUSY] = busy;
    ctrl_word[CTRL_DONE] = done;
    ctrl_word[CTRL_ERR]  = err;
    ctrl_word[CTRL_LVL_LSB +: 2] = levels;
  end

  // A stalled data read is answered from its captured offset once idle.
  always_comb begin
    rd_off  = pending ? pend_off : off;
    rd_word = '0;
    if (rd_off < 32'(NN)) begin
      for (int b = 0; b < 4; b++) rd_word[8*b +: DW] = in_mem[{rd_off[SW-1:2], 2'(b)}];
    end else if (rd_off < 32'(2 * NN)) begin
      for (int b = 0; b < 4; b++) rd_word[8*b +: DW] = out_mem[{rd_off[SW-1:2], 2'(b)}];
    end else if (rd_off[31:2] == 30'(2 * NN / 4)) begin
      rd_word = ctrl_word;
    end
  end

  always_comb begin
    for (int j = 0; j < 5; j++)
      tap_idx[j] = IW'(mirror_idx(2 * int'(cnt) + j - 2, int'(l_w)));
    for (int r = 0; r < N; r++)
      for (int j = 0; j < 5; j++) tap_sel[r][j] = w[r][tap_idx[j]];
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    dwt53_lane #(.DW(DW)) u_lane (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .vld_i    (issue_vld),
      .x_i      (tap_sel[r]),
      .vld_o    (vld_lane[r]),
      .low_o    (low_c[r]),
      .high_o   (high_c[r])
    );
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lvl       <= '0;
      levels    <= '0;
      col_phase <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pending   <= 1'b0;
      pend_off  <= '0;
      ready_o   <= 1'b0;
      rdata_o   <= '0;
    end else begin
      ready_o <= 1'b0;
      if (accept) begin
        if (!is_wr && (in_rgn || out_rgn) && busy) begin
          pending  <= 1'b1;
          pend_off <= off;
        end else begin
          ready_o <= 1'b1;
          rdata_o <= is_wr ? '0 : rd_word;
        end
        if (is_wr && ctrl_rgn) begin
          done <= 1'b0;
          err  <= 1'b0;
          if (wstrb_i[0] && wdata_i[CTRL_START]) begin
            if (busy) begin
              err <= 1'b1;
            end else begin
              state  <= ST_LOAD;
              levels <= clamp_levels(wdata_i[CTRL_LVL_LSB +: 2]);
            end
          end
        end
        if (is_wr && in_rgn && busy) err <= 1'b1;
      end else if (pending && !busy) begin
        ready_o <= 1'b1;
        rdata_o <= rd_word;
        pending <= 1'b0;
      end

      case (state)
        ST_LOAD: begin
          state <= ST_ROW;
          cnt   <= '0;
          lvl   <= '0;
        end
        ST_ROW, ST_COL: begin
          cnt <= cnt + 1'b1;
          if (pass_end) begin
            state     <= ST_XPOSE;
            col_phase <= (state == ST_COL);
            cnt       <= '0;
          end
        end
        ST_XPOSE: begin
          if (!col_phase) begin
            state <= ST_COL;
          end else if (lvl == levels - 2'd1) begin
            state <= ST_STORE;
          end else begin
            lvl   <= lvl + 2'd1;
            state <= ST_ROW;
          end
        end
        ST_STORE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lines of the working array are rows in ROW and columns (after XPOSE) in COL.
  always_ff @(posedge clk_i) begin
    if (accept && is_wr && in_rgn && !busy) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) in_mem[{off[SW-1:2], 2'(b)}] <= wdata_i[8*b +: DW];
    end
    k_p0 <= cnt[IW-1:0];
    k_p1 <= k_p0;
    if (vld_all) begin
      for (int r = 0; r < N; r++) begin
        if (r < int'(l_w)) begin
          t[r][k_p1]               <= low_c[r];
          t[r][lh[IW-1:0] + k_p1]  <= high_c[r];
        end
      end
    end
    case (state)
      ST_LOAD: begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) w[i][j] <= in_mem[SW'(i * N + j)];
      end
      ST_XPOSE: begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if ((i < int'(l_w)) && (j < int'(l_w))) w[i][j] <= t[j][i];
            else w[i][j] <= w[j][i];
      end
      ST_STORE: begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) out_mem[SW'(i * N + j)] <= w[i][j];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wavelet_unit.sv
// Directed bench for wavelet_unit (N=8, DW=8, 3 levels max) over the native bus.
module tb_wavelet_unit;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] IN_A   = BASE;
  localparam logic [31:0] OUT_A  = BASE + 32'd64;
  localparam logic [31:0] CTRL_A = BASE + 32'd128;
`ifdef WAVELET_SAT_EN
  localparam logic [31:0] ALT_HI = 32'h8080_8080;
`else
  localparam logic [31:0] ALT_HI = 32'h0101_0101;
`endif

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  wstrb_i = 4'h0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  wavelet_unit #(.BASE_ADDRESS(BASE), .N(8), .DW(8), .MAX_LEVELS(3)) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .wstrb_i  (wstrb_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    @(posedge clk_i);
    #1;
    valid_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = s;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk_i);
      #1;
      if (ready_o) break;
    end
    chk("handshake", {31'b0, ready_o}, 32'd1);
    rd = rdata_o;
    valid_i = 1'b0; wstrb_i = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(a, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    xfer(a, 32'h0, 4'h0, d);
  endtask

  task automatic fill(input logic [31:0] word);
    for (int i = 0; i < 16; i++) wr(IN_A + 32'(4 * i), word);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] exp_w;
    int t0;

    // Reset state
    #3 resetn_i = 1'b0;
    #2;
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    rd(CTRL_A, r);
    chk("ctrl_after_reset", r, 32'h0);

    // All-zero input, 3 levels: 34 busy cycles, stalled read answers one cycle later
    fill(32'h0);
    wr(CTRL_A, 32'h31);
    t0 = cyc;
    rd(OUT_A, r);
    chk("zero_latency", 32'(cyc - t0), 32'd35);
    chk("zero_out0", r, 32'h0);
    rd(CTRL_A, r);
    chk("zero_ctrl", r, 32'h32);
    for (int i = 1; i < 16; i++) begin
      rd(OUT_A + 32'(4 * i), r);
      chk("zero_out", r, 32'h0);
    end

    // Constant 16, 3 levels: only the DC coefficient survives
    fill(32'h1010_1010);
    wr(CTRL_A, 32'h31);
    rd(OUT_A, r);
    chk("dc_out0", r, 32'h0000_0010);
    for (int i = 1; i < 16; i++) begin
      rd(OUT_A + 32'(4 * i), r);
      chk("dc_out", r, 32'h0);
    end

    // Alternating 127,-128 rows, level field 0 -> one level
    fill(32'h807F_807F);
    wr(CTRL_A, 32'h01);
    t0 = cyc;
    rd(OUT_A, r);
    chk("alt_latency", 32'(cyc - t0), 32'd17);
    chk("alt_out0", r, 32'hFFFF_FFFF);
    for (int i = 1; i < 16; i++) begin
      rd(OUT_A + 32'(4 * i), r);
      exp_w = (i >= 8) ? 32'h0 : ((i % 2 == 0) ? 32'hFFFF_FFFF : ALT_HI);
      chk("alt_out", r, exp_w);
    end
    rd(CTRL_A, r);
    chk("alt_ctrl", r, 32'h12);

    // Start while busy: dropped, err raised, levels unchanged
    wr(CTRL_A, 32'h01);
    wr(CTRL_A, 32'h31);
    rd(CTRL_A, r);
    chk("busy_err_ctrl", r, 32'h15);
    rd(OUT_A + 32'd4, r);
    chk("busy_err_out1", r, ALT_HI);
    rd(CTRL_A, r);
    chk("busy_err_done", r, 32'h16);
    wr(CTRL_A, 32'h0);
    rd(CTRL_A, r);
    chk("err_cleared", r, 32'h10);

    // Out-of-window accesses and byte strobes
    rd(BASE + 32'h1000, r);
    chk("oow_read", r, 32'h0);
    wr(BASE + 32'h1000, 32'h1234_5678);
    wr(BASE - 32'd4, 32'h1234_5678);
    rd(IN_A, r);
    chk("oow_no_effect", r, 32'h807F_807F);
    xfer(IN_A, 32'hAAAA_AA11, 4'b0001, r);
    rd(IN_A, r);
    chk("strobe_byte0", r, 32'h807F_8011);

    // Reset mid-operation, stale output, then a fresh run
    fill(32'h1010_1010);
    wr(CTRL_A, 32'h31);
    rd(CTRL_A, r);
    chk("run_ctrl_busy", r, 32'h31);
    repeat (8) @(posedge clk_i);
    #1 resetn_i = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, ready_o}, 32'd0);
    chk("midrst_rdata", rdata_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    rd(CTRL_A, r);
    chk("midrst_ctrl", r, 32'h0);
    rd(OUT_A, r);
    chk("midrst_stale_out", r, 32'hFFFF_FFFF);
    wr(CTRL_A, 32'h31);
    t0 = cyc;
    rd(OUT_A, r);
    chk("fresh_latency", 32'(cyc - t0), 32'd35);
    chk("fresh_out0", r, 32'h0000_0010);
    rd(OUT_A + 32'd36, r);
    chk("fresh_out9", r, 32'h0);
    rd(CTRL_A, r);
    chk("fresh_ctrl", r, 32'h32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
